// File: rtl/parity_pkg.sv
// Shared definitions for the serial parity link.
// Parity sense constants and the receiver FSM state encoding.
package parity_pkg;

    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

endpackage

// File: rtl/parity_checker.sv
// Serial parity checker / deserializer at the far end of the link.
// Frames start bit, LSB-first data and parity; counts parity errors.
module parity_checker
    import parity_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 x,
    input  logic                 x_en,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 done,
    output logic                 err,
    output logic                 busy,
    output logic [7:0]           err_count
);

    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_BITS - 1);
    localparam logic SENSE = (ODD_PARITY != 0) ? ODD : EVEN;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 par_q, par_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [7:0]           ecnt_q, ecnt_d;
    logic                 mism;

    // Next-state: framing FSM, shift register, counters and result capture
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = err_q;
        ecnt_d  = ecnt_q;
        mism    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (x_en && !x) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    par_d   = EVEN;
                end
            end
            DATA: begin
                if (x_en) begin
                    shift_d = {x, shift_q[DATA_BITS-1:1]};
                    par_d   = par_q ^ x;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (x_en) begin
                    mism    = par_q ^ x ^ SENSE;
                    data_d  = shift_q;
                    err_d   = mism;
                    done_d  = 1'b1;
                    if (mism && (ecnt_q != 8'hFF)) begin
                        ecnt_d = ecnt_q + 8'd1;
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= EVEN;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ecnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ecnt_q  <= ecnt_d;
        end
    end

    assign data_out  = data_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = (state_q != IDLE);
    assign err_count = ecnt_q;

endmodule

// File: tb/tb_parity_checker.sv
// Scoreboard bench for parity_checker: even and odd instances.
// Drivers push expected results; monitors pop them on each done.
module tb_parity_checker;

    typedef struct {
        logic [7:0] data;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       xe = 1'b1, xe_en = 1'b0;
    logic       xo = 1'b1, xo_en = 1'b0;
    logic [7:0] de, dd;
    logic       done_e, err_e, busy_e;
    logic       done_o, err_o, busy_o;
    logic [7:0] cnt_e, cnt_o;

    exp_t q_e[$];
    exp_t q_o[$];
    int   checks = 0;
    int   passes = 0;
    int   mcnt_e = 0;
    int   mcnt_o = 0;
    int   sent_e = 0, sent_o = 0;
    int   seen_e = 0, seen_o = 0;
    logic prev_e = 1'b0, prev_o = 1'b0;

    always #5 clk = ~clk;

    parity_checker #(.DATA_BITS(8), .ODD_PARITY(0)) u_even (
        .clk(clk), .rst(rst), .x(xe), .x_en(xe_en),
        .data_out(de), .done(done_e), .err(err_e),
        .busy(busy_e), .err_count(cnt_e)
    );

    parity_checker #(.DATA_BITS(8), .ODD_PARITY(1)) u_odd (
        .clk(clk), .rst(rst), .x(xo), .x_en(xo_en),
        .data_out(dd), .done(done_o), .err(err_o),
        .busy(busy_o), .err_count(cnt_o)
    );

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", n, act, exp);
    endtask

    // Even monitor
    always @(negedge clk) begin
        if (!rst && done_e) begin
            exp_t e;
            seen_e++;
            chk("even_done_width", int'(prev_e), 0);
            if (q_e.size() == 0) begin
                chk("even_unexpected_done", 1, 0);
            end else begin
                e = q_e.pop_front();
                chk("even_data", int'(de), int'(e.data));
                chk("even_err", int'(err_e), int'(e.err));
                chk("even_cnt", int'(cnt_e), int'(e.cnt));
            end
        end
        prev_e <= done_e;
    end

    // Odd monitor
    always @(negedge clk) begin
        if (!rst && done_o) begin
            exp_t e;
            seen_o++;
            chk("odd_done_width", int'(prev_o), 0);
            if (q_o.size() == 0) begin
                chk("odd_unexpected_done", 1, 0);
            end else begin
                e = q_o.pop_front();
                chk("odd_data", int'(dd), int'(e.data));
                chk("odd_err", int'(err_o), int'(e.err));
                chk("odd_cnt", int'(cnt_o), int'(e.cnt));
            end
        end
        prev_o <= done_o;
    end

    task automatic drive(input bit odd, input logic b, input bit gap);
        @(negedge clk);
        if (odd) begin xo = b; xo_en = 1'b1; end
        else begin xe = b; xe_en = 1'b1; end
        if (gap) begin
            @(negedge clk);
            if (odd) xo_en = 1'b0;
            else xe_en = 1'b0;
        end
    endtask

    task automatic idle(input bit odd, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (odd) begin xo = 1'b1; xo_en = 1'b1; end
            else begin xe = 1'b1; xe_en = 1'b1; end
        end
    endtask

    task automatic send(input bit odd, input logic [7:0] d,
                        input logic p, input logic exp_err,
                        input bit gap);
        exp_t e;
        logic [7:0] dv;
        dv = d;
        e.data = d;
        e.err = exp_err;
        if (odd) begin
            if (exp_err && mcnt_o < 255) mcnt_o++;
            e.cnt = 8'(mcnt_o);
            q_o.push_back(e);
            sent_o++;
        end else begin
            if (exp_err && mcnt_e < 255) mcnt_e++;
            e.cnt = 8'(mcnt_e);
            q_e.push_back(e);
            sent_e++;
        end
        drive(odd, 1'b0, gap);
        for (int i = 0; i < 8; i++) drive(odd, dv[i], gap);
        if (!gap) @(negedge clk);
        if (odd) begin
            chk("odd_busy_mid", int'(busy_o), 1);
            chk("odd_no_early_done", int'(done_o), 0);
        end else begin
            chk("even_busy_mid", int'(busy_e), 1);
            chk("even_no_early_done", int'(done_e), 0);
        end
        if (gap) drive(odd, p, gap);
        else begin
            if (odd) begin xo = p; xo_en = 1'b1; end
            else begin xe = p; xe_en = 1'b1; end
        end
    endtask

    initial begin
        int busy_hi;
        repeat (3) @(negedge clk);
        chk("rst_data", int'(de), 0);
        chk("rst_done", int'(done_e), 0);
        chk("rst_err", int'(err_e), 0);
        chk("rst_busy", int'(busy_e), 0);
        chk("rst_cnt", int'(cnt_e), 0);
        rst = 1'b0;
        idle(0, 2);

        send(0, 8'hA5, 1'b0, 1'b0, 0);
        idle(0, 3);
        send(0, 8'hA5, 1'b1, 1'b1, 0);
        send(0, 8'h01, 1'b1, 1'b0, 0);
        idle(0, 3);

        send(0, 8'h3C, 1'b0, 1'b0, 1);
        idle(0, 3);

        busy_hi = 0;
        for (int i = 0; i < 20; i++) begin
            idle(0, 1);
            if (busy_e) busy_hi++;
        end
        chk("idle_busy_cycles", busy_hi, 0);
        send(0, 8'h00, 1'b0, 1'b0, 0);
        idle(0, 3);

        drive(0, 1'b0, 0);
        for (int i = 0; i < 4; i++) drive(0, 1'b1, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_data", int'(de), 0);
        chk("arst_err", int'(err_e), 0);
        chk("arst_busy", int'(busy_e), 0);
        chk("arst_cnt", int'(cnt_e), 0);
        chk("arst_done", int'(done_e), 0);
        mcnt_e = 0;
        xe = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(0, 2);
        send(0, 8'h81, 1'b0, 1'b0, 0);
        idle(0, 3);

        idle(1, 2);
        send(1, 8'h07, 1'b0, 1'b0, 0);
        for (int i = 0; i < 256; i++) send(1, 8'h07, 1'b1, 1'b1, 0);
        idle(1, 4);
        chk("odd_sat_cnt", int'(cnt_o), 255);

        chk("even_queue_empty", q_e.size(), 0);
        chk("odd_queue_empty", q_o.size(), 0);
        chk("even_done_count", seen_e, sent_e);
        chk("odd_done_count", seen_o, sent_o);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
